issue_stage: RTL and testbench

Issue stage of the in-order pipeline, sitting between decode and execute and directly in front of the register file's read ports. Drives the regfile read addresses, bypasses same-cycle writeback data, tracks outstanding destination writes in a 32-bit scoreboard, and blocks on RAW/WAW hazards. It registers the operand values and destination into a valid/ready pipeline register for execute, and counts hazard/backpressure stall cycles.

---
 rtl/issue_stage.sv | 96 +++++++++
 tb/tb_issue_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_stage.sv
// Issue stage: scoreboarded RAW/WAW hazard blocking, writeback bypass and a
// valid/ready operand register feeding execute.
module issue_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic              in_uses_rs1,
  input  logic              in_uses_rs2,
  input  logic [4:0]        in_rd,
  input  logic              in_rd_we,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              wb_valid,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rs1_data,
  output logic [DATA_W-1:0] out_rs2_data,
  output logic [4:0]        out_rd,
  output logic              out_rd_we,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int unsigned NREG = 32;

  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_n;
  logic              wb_clr;
  logic              wb_hit1, wb_hit2, wb_hit_rd;
  logic              haz1, haz2, waw;
  logic              issue_ok, out_free, fire, stall;
  logic [DATA_W-1:0] op1, op2;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  // A writeback landing this edge releases its register in the same cycle.
  assign wb_clr    = wb_valid && (wb_addr != 5'd0);
  assign wb_hit1   = wb_clr && (wb_addr == in_rs1);
  assign wb_hit2   = wb_clr && (wb_addr == in_rs2);
  assign wb_hit_rd = wb_clr && (wb_addr == in_rd);

  assign haz1 = in_uses_rs1 && busy_q[in_rs1] && !wb_hit1;
  assign haz2 = in_uses_rs2 && busy_q[in_rs2] && !wb_hit2;
  assign waw  = in_rd_we && (in_rd != 5'd0) && busy_q[in_rd] && !wb_hit_rd;

  assign issue_ok = !haz1 && !haz2 && !waw;
  assign out_free = !out_valid || out_ready;
  assign in_ready = issue_ok && out_free;
  assign fire     = in_valid && in_ready;
  assign stall    = in_valid && !in_ready;

  assign op1 = (in_rs1 == 5'd0) ? DATA_W'(0) : (wb_hit1 ? wb_data : rf_rdata1);
  assign op2 = (in_rs2 == 5'd0) ? DATA_W'(0) : (wb_hit2 ? wb_data : rf_rdata2);

  // Clear from writeback first so a same-cycle set on the same index wins.
  always_comb begin
    busy_n = busy_q;
    if (wb_clr) busy_n[wb_addr] = 1'b0;
    if (fire && in_rd_we && (in_rd != 5'd0)) busy_n[in_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q       <= '0;
      out_valid    <= 1'b0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rd       <= '0;
      out_rd_we    <= 1'b0;
      stall_count  <= '0;
    end else begin
      busy_q <= busy_n;
      if (fire) begin
        out_valid    <= 1'b1;
        out_rs1_data <= op1;
        out_rs2_data <= op2;
        out_rd       <= in_rd;
        out_rd_we    <= in_rd_we;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_issue_stage.sv
// Directed testbench for issue_stage with a small behavioural regfile.
module tb_issue_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready;
  logic [4:0]        in_rs1, in_rs2, in_rd;
  logic              in_uses_rs1, in_uses_rs2, in_rd_we;
  logic [4:0]        rf_raddr1, rf_raddr2;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2;
  logic              wb_valid;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_rs1_data, out_rs2_data;
  logic [4:0]        out_rd;
  logic              out_rd_we;
  logic [CNT_W-1:0]  stall_count;

  logic [DATA_W-1:0] rf [32];

  int tests_run = 0;
  int tests_failed = 0;

  issue_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_rd_we(out_rd_we),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Regfile: x0 deliberately reads all-ones to prove the stage forces zero.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h1000 + 32'(i);
      rf[0] <= 32'hFFFF_FFFF;
      rf[1] <= 32'h11;
      rf[2] <= 32'h22;
    end else if (wb_valid && wb_addr != 5'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd, input logic we);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2;
    in_uses_rs1 = u1; in_uses_rs2 = u2; in_rd = rd; in_rd_we = we;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] a, input logic [DATA_W-1:0] d);
    wb_valid = v; wb_addr = a; wb_data = d;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_rs1", 64'(out_rs1_data), 64'd0);
    check("rst_rs2", 64'(out_rs2_data), 64'd0);
    check("rst_rd", 64'(out_rd), 64'd0);
    check("rst_rd_we", 64'(out_rd_we), 64'd0);
    check("rst_stall", 64'(stall_count), 64'd0);
    reset = 1'b0;

    // Independent issue and follower
    out_ready = 1'b1;
    set_in(1, 1, 2, 1, 1, 3, 1);
    #1;
    check("indep_ready", 64'(in_ready), 64'd1);
    check("raddr1", 64'(rf_raddr1), 64'd1);
    check("raddr2", 64'(rf_raddr2), 64'd2);
    tick();
    check("a_valid", 64'(out_valid), 64'd1);
    check("a_rs1", 64'(out_rs1_data), 64'h11);
    check("a_rs2", 64'(out_rs2_data), 64'h22);
    check("a_rd", 64'(out_rd), 64'd3);
    check("a_we", 64'(out_rd_we), 64'd1);
    set_in(1, 1, 2, 1, 1, 4, 1);
    #1;
    check("follow_ready", 64'(in_ready), 64'd1);
    tick();
    check("b_rd", 64'(out_rd), 64'd4);

    // RAW on x3 resolved by bypass; x0 source and x0 destination
    set_in(1, 3, 0, 1, 1, 0, 1);
    #1;
    check("raw3_block", 64'(in_ready), 64'd0);
    tick();
    check("drain_valid", 64'(out_valid), 64'd0);
    set_wb(1, 3, 32'h333);
    #1;
    check("raw3_bypass_ready", 64'(in_ready), 64'd1);
    check("stall_1", 64'(stall_count), 64'd1);
    tick();
    check("c_rs1_bypass", 64'(out_rs1_data), 64'h333);
    check("c_rs2_x0", 64'(out_rs2_data), 64'd0);
    check("c_rd", 64'(out_rd), 64'd0);

    // RAW on x5 with two blocked cycles
    set_wb(0, 0, 0);
    set_in(1, 0, 0, 0, 0, 5, 1);
    tick();
    set_in(1, 5, 2, 1, 1, 6, 1);
    #1;
    check("raw5_block0", 64'(in_ready), 64'd0);
    tick();
    check("raw5_block1", 64'(in_ready), 64'd0);
    tick();
    set_wb(1, 5, 32'hDEAD);
    #1;
    check("raw5_ready", 64'(in_ready), 64'd1);
    check("stall_3", 64'(stall_count), 64'd3);
    tick();
    check("e_rs1_dead", 64'(out_rs1_data), 64'hDEAD);
    check("e_rs2", 64'(out_rs2_data), 64'h22);
    check("e_rd", 64'(out_rd), 64'd6);

    // wb to x0 must not bypass
    set_wb(1, 0, 32'hBAD);
    set_in(1, 0, 1, 1, 1, 7, 1);
    tick();
    set_wb(0, 0, 0);
    check("f_rs1_x0", 64'(out_rs1_data), 64'd0);
    check("f_rs2", 64'(out_rs2_data), 64'h11);
    check("f_rd", 64'(out_rd), 64'd7);

    // Backpressure for three cycles
    out_ready = 1'b0;
    set_in(1, 1, 2, 1, 1, 8, 1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", 64'(in_ready), 64'd0);
      tick();
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_rd", 64'(out_rd), 64'd7);
      check("bp_rs2", 64'(out_rs2_data), 64'h11);
    end
    check("stall_6", 64'(stall_count), 64'd6);
    out_ready = 1'b1;
    #1;
    check("bp_release", 64'(in_ready), 64'd1);
    tick();
    check("g_rd", 64'(out_rd), 64'd8);
    check("g_rs1", 64'(out_rs1_data), 64'h11);
    check("stall_6b", 64'(stall_count), 64'd6);

    // Same-cycle clear and set of x7: set wins
    set_in(1, 0, 0, 0, 0, 7, 1);
    set_wb(1, 7, 32'h777);
    #1;
    check("collide_ready", 64'(in_ready), 64'd1);
    tick();
    set_wb(0, 0, 0);
    set_in(1, 7, 0, 1, 0, 9, 1);
    #1;
    check("x7_still_busy0", 64'(in_ready), 64'd0);
    tick();
    check("x7_still_busy1", 64'(in_ready), 64'd0);
    tick();
    set_wb(1, 7, 32'h7070);
    #1;
    check("x7_release", 64'(in_ready), 64'd1);
    tick();
    set_wb(0, 0, 0);
    check("i_rs1", 64'(out_rs1_data), 64'h7070);
    check("i_rd", 64'(out_rd), 64'd9);
    check("stall_8", 64'(stall_count), 64'd8);

    // WAW on x4 then async reset between edges
    set_in(1, 0, 0, 0, 0, 4, 1);
    #1;
    check("waw4_block", 64'(in_ready), 64'd0);
    #1;
    reset = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_rs1", 64'(out_rs1_data), 64'd0);
    check("arst_rd", 64'(out_rd), 64'd0);
    check("arst_we", 64'(out_rd_we), 64'd0);
    check("arst_stall", 64'(stall_count), 64'd0);
    check("arst_busy_clear", 64'(in_ready), 64'd1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    set_in(1, 3, 0, 1, 0, 4, 1);
    #1;
    check("post_rst_ready", 64'(in_ready), 64'd1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_rs1", 64'(out_rs1_data), 64'h1003);
    check("post_rst_rd", 64'(out_rd), 64'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
